audio_synth_timer_sequencer: RTL

Avalon-MM master that owns the SoC's 16-bit-register interval timer and sequences it on behalf of the synthesizer's audio/tempo logic. It accepts START/STOP/SNAPSHOT commands over a valid/ready handshake and translates them into timer register writes. It services the timer IRQ in hardware and emits one `tick` pulse per timeout, so no CPU interrupt handler is needed. It sits between the note scheduler and the timer's `s1` slave, with the timer `irq` wired to this block instead of the CPU.

---
 rtl/audio_synth_timer_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/audio_synth_timer_sequencer.sv
// Sequences the SoC interval timer over Avalon-MM: START/STOP/SNAPSHOT commands, hardware IRQ service, tick pulses.
// Optional snapshot read-back is built only when TIMER_SEQ_SNAPSHOT_EN is defined.
module audio_synth_timer_sequencer #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    output logic [3:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [63:0]       snap_value
);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_SNAP  = 2'd2;

    typedef enum logic [4:0] {
        IDLE, RUN, LOAD0, LOAD1, LOAD2, LOAD3, CTRL, ACK, ACK_WAIT, STOP_CTL, STOP_CLR
`ifdef TIMER_SEQ_SNAPSHOT_EN
        , SNAP_WR, SNAP_RD0, SNAP_RD1, SNAP_RD2, SNAP_RD3, SNAP_RD4
`endif
    } state_t;

    state_t      state, state_nx;
    logic        accept;
    logic [31:0] eff_period;
    logic [15:0] period_hi;
    logic        wr_en, rd_en;
    logic [3:0]  addr_nx;
    logic [15:0] data_nx;
    logic        snap_ret_run;

    // The timer reloads on zero, so it must be loaded with period-1; 1 is the shortest legal load.
    assign eff_period = (cmd_period < 32'd2) ? 32'd1 : cmd_period - 32'd1;
    assign cmd_ready  = !reset && (state == IDLE || state == RUN) && !timer_irq;
    assign accept     = cmd_valid && cmd_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RUN: begin
                if (state == RUN && timer_irq) begin
                    state_nx = ACK;
                end else if (accept) begin
                    case (cmd_op)
                        OP_START: state_nx = LOAD0;
                        OP_STOP:  state_nx = STOP_CTL;
`ifdef TIMER_SEQ_SNAPSHOT_EN
                        OP_SNAP:  state_nx = SNAP_WR;
`endif
                        default:  state_nx = state;
                    endcase
                end
            end
            LOAD0:    state_nx = LOAD1;
            LOAD1:    state_nx = LOAD2;
            LOAD2:    state_nx = LOAD3;
            LOAD3:    state_nx = CTRL;
            CTRL:     state_nx = RUN;
            ACK:      state_nx = ACK_WAIT;
            ACK_WAIT: state_nx = RUN;
            STOP_CTL: state_nx = STOP_CLR;
            STOP_CLR: state_nx = IDLE;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR:  state_nx = SNAP_RD0;
            SNAP_RD0: state_nx = SNAP_RD1;
            SNAP_RD1: state_nx = SNAP_RD2;
            SNAP_RD2: state_nx = SNAP_RD3;
            SNAP_RD3: state_nx = SNAP_RD4;
            SNAP_RD4: state_nx = snap_ret_run ? RUN : IDLE;
`endif
            default:  state_nx = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each access lines up with its state.
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr_nx = avm_address;
        data_nx = avm_writedata;
        case (state_nx)
            LOAD0:    begin wr_en = 1'b1; addr_nx = 4'd2; data_nx = eff_period[15:0]; end
            LOAD1:    begin wr_en = 1'b1; addr_nx = 4'd3; data_nx = period_hi;        end
            LOAD2:    begin wr_en = 1'b1; addr_nx = 4'd4; data_nx = 16'h0000;         end
            LOAD3:    begin wr_en = 1'b1; addr_nx = 4'd5; data_nx = 16'h0000;         end
            CTRL:     begin wr_en = 1'b1; addr_nx = 4'd1; data_nx = 16'h0007;         end
            ACK:      begin wr_en = 1'b1; addr_nx = 4'd0; data_nx = 16'h0000;         end
            STOP_CTL: begin wr_en = 1'b1; addr_nx = 4'd1; data_nx = 16'h0008;         end
            STOP_CLR: begin wr_en = 1'b1; addr_nx = 4'd0; data_nx = 16'h0000;         end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR:  begin wr_en = 1'b1; addr_nx = 4'd6; data_nx = 16'h0000;         end
            SNAP_RD0: begin rd_en = 1'b1; addr_nx = 4'd6; end
            SNAP_RD1: begin rd_en = 1'b1; addr_nx = 4'd7; end
            SNAP_RD2: begin rd_en = 1'b1; addr_nx = 4'd8; end
            SNAP_RD3: begin rd_en = 1'b1; addr_nx = 4'd9; end
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 4'd0;
            avm_writedata  <= 16'h0000;
            running        <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            period_hi      <= 16'h0000;
        end else begin
            state          <= state_nx;
            avm_chipselect <= wr_en | rd_en;
            avm_write_n    <= !wr_en;
            avm_address    <= addr_nx;
            avm_writedata  <= data_nx;
            tick           <= (state_nx == ACK);
            // Period writes halt the timer, so a restart is not running until CTRL re-arms it.
            if (state == CTRL)
                running <= 1'b1;
            else if (state_nx == STOP_CTL || state_nx == LOAD0)
                running <= 1'b0;
            if (accept && cmd_op == OP_START) begin
                tick_count <= '0;
                period_hi  <= eff_period[31:16];
            end else if (state == ACK) begin
                tick_count <= tick_count + 1'b1;
            end
        end
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [63:0] snap_q;

    // Read data lags its address by one cycle, so each halfword lands one state after it was addressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q       <= 64'd0;
            snap_ret_run <= 1'b0;
        end else begin
            if (accept && cmd_op == OP_SNAP)
                snap_ret_run <= (state == RUN);
            case (state)
                SNAP_RD1: snap_q[15:0]  <= avm_readdata;
                SNAP_RD2: snap_q[31:16] <= avm_readdata;
                SNAP_RD3: snap_q[47:32] <= avm_readdata;
                SNAP_RD4: snap_q[63:48] <= avm_readdata;
                default:  ;
            endcase
        end
    end

    assign snap_valid = (state == SNAP_RD4);
    assign snap_value = (state == SNAP_RD4) ? {avm_readdata, snap_q[47:0]} : snap_q;
`else
    logic unused_rd;
    assign unused_rd    = ^avm_readdata;
    assign snap_ret_run = 1'b0;
    assign snap_valid   = 1'b0;
    assign snap_value   = 64'd0;
`endif

endmodule
